rv_execute_stage: RTL and testbench



---
 rtl/rv_execute_stage_if.sv | 52 +++++
 rtl/rv_execute_stage.sv | 119 +++++++++++
 tb/tb_rv_execute_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_execute_stage_if.sv
// Signal bundle between decode/hazard logic (master) and the execute slice (slave).
interface rv_execute_stage_if;
   logic        id_clear, id_wr_en, ex_clear, ex_wr_en;
   logic        id_jump, id_branch, id_mem_read, id_reg_wr_en, id_mem_wr_en;
   logic        id_op1_sel, id_op2_sel;
   logic [3:0]  id_alu_op;
   logic [1:0]  id_wb_sel;
   logic [2:0]  id_mem_ctrl;
   logic [31:0] id_pc, id_pc_next, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [1:0]  fwd1_sel, fwd2_sel;
   logic [31:0] wb_data;

   logic        ex_jump, ex_branch, ex_mem_read;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1_fwd, ex_rs2_fwd, ex_alu_result;
   logic [1:0]  mem_wb_sel;
   logic        mem_reg_wr_en, mem_mem_wr_en;
   logic [2:0]  mem_mem_ctrl;
   logic [4:0]  mem_rd;
   logic [31:0] mem_pc_next, mem_alu_result, mem_store_data;

   modport master (
      output id_clear, id_wr_en, ex_clear, ex_wr_en,
             id_jump, id_branch, id_mem_read, id_reg_wr_en, id_mem_wr_en,
             id_op1_sel, id_op2_sel, id_alu_op, id_wb_sel, id_mem_ctrl,
             id_pc, id_pc_next, id_rs1_data, id_rs2_data, id_imm,
             id_rd, id_rs1, id_rs2, id_opcode, id_funct3,
             fwd1_sel, fwd2_sel, wb_data,
      input  ex_jump, ex_branch, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
             ex_opcode, ex_funct3, ex_rs1_fwd, ex_rs2_fwd, ex_alu_result,
             mem_wb_sel, mem_reg_wr_en, mem_mem_wr_en, mem_mem_ctrl, mem_rd,
             mem_pc_next, mem_alu_result, mem_store_data
   );

   modport slave (
      input  id_clear, id_wr_en, ex_clear, ex_wr_en,
             id_jump, id_branch, id_mem_read, id_reg_wr_en, id_mem_wr_en,
             id_op1_sel, id_op2_sel, id_alu_op, id_wb_sel, id_mem_ctrl,
             id_pc, id_pc_next, id_rs1_data, id_rs2_data, id_imm,
             id_rd, id_rs1, id_rs2, id_opcode, id_funct3,
             fwd1_sel, fwd2_sel, wb_data,
      output ex_jump, ex_branch, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
             ex_opcode, ex_funct3, ex_rs1_fwd, ex_rs2_fwd, ex_alu_result,
             mem_wb_sel, mem_reg_wr_en, mem_mem_wr_en, mem_mem_ctrl, mem_rd,
             mem_pc_next, mem_alu_result, mem_store_data
   );
endinterface

// File: rtl/rv_execute_stage.sv
// RV32I execute slice: ID/EX register, operand forwarding/select, ALU, EX/MEM register.
module rv_execute_stage (
   input  logic              clk,
   input  logic              rst_n,
   rv_execute_stage_if.slave bus
);
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
      ALU_SLTU = 4'd4,  ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
      ALU_OR   = 4'd8,  ALU_AND = 4'd9, ALU_PASS = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic        jump, branch, mem_read, reg_wr_en, mem_wr_en, op1_sel, op2_sel;
      logic [3:0]  alu_op;
      logic [1:0]  wb_sel;
      logic [2:0]  mem_ctrl;
      logic [31:0] pc, pc_next, rs1_data, rs2_data, imm;
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
   } id_ex_t;

   typedef struct packed {
      logic [1:0]  wb_sel;
      logic        reg_wr_en, mem_wr_en;
      logic [2:0]  mem_ctrl;
      logic [31:0] pc_next, alu_result, store_data;
      logic [4:0]  rd;
   } ex_mem_t;

   id_ex_t      id_in, id_ex;
   ex_mem_t     ex_in, ex_mem;
   logic [31:0] rs1_fwd, rs2_fwd, op1, op2, alu_result;
   logic [4:0]  shamt;

   function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_data,
                                           input logic [31:0] mem_data, input logic [31:0] wb);
      case (sel)
         2'd1:    return mem_data;
         2'd2:    return wb;
         default: return reg_data;
      endcase
   endfunction

   always_comb begin
      id_in = '{jump: bus.id_jump, branch: bus.id_branch, mem_read: bus.id_mem_read,
                reg_wr_en: bus.id_reg_wr_en, mem_wr_en: bus.id_mem_wr_en,
                op1_sel: bus.id_op1_sel, op2_sel: bus.id_op2_sel, alu_op: bus.id_alu_op,
                wb_sel: bus.id_wb_sel, mem_ctrl: bus.id_mem_ctrl, pc: bus.id_pc,
                pc_next: bus.id_pc_next, rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data,
                imm: bus.id_imm, rd: bus.id_rd, rs1: bus.id_rs1, rs2: bus.id_rs2,
                opcode: bus.id_opcode, funct3: bus.id_funct3};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             id_ex <= '0;
      else if (bus.id_clear)  id_ex <= '0;
      else if (bus.id_wr_en)  id_ex <= id_in;
   end

   always_comb begin
      rs1_fwd = fwd_mux(bus.fwd1_sel, id_ex.rs1_data, ex_mem.alu_result, bus.wb_data);
      rs2_fwd = fwd_mux(bus.fwd2_sel, id_ex.rs2_data, ex_mem.alu_result, bus.wb_data);
      op1     = id_ex.op1_sel ? id_ex.pc : rs1_fwd;
      op2     = id_ex.op2_sel ? rs2_fwd : id_ex.imm;
      shamt   = op2[4:0];
   end

   always_comb begin
      alu_result = '0;
      case (id_ex.alu_op)
         ALU_ADD:  alu_result = op1 + op2;
         ALU_SUB:  alu_result = op1 - op2;
         ALU_SLL:  alu_result = op1 << shamt;
         ALU_SLT:  alu_result = {31'd0, $signed(op1) < $signed(op2)};
         ALU_SLTU: alu_result = {31'd0, op1 < op2};
         ALU_XOR:  alu_result = op1 ^ op2;
         ALU_SRL:  alu_result = op1 >> shamt;
         ALU_SRA:  alu_result = $unsigned($signed(op1) >>> shamt);
         ALU_OR:   alu_result = op1 | op2;
         ALU_AND:  alu_result = op1 & op2;
         ALU_PASS: alu_result = op2;
         default:  alu_result = '0;
      endcase
   end

   always_comb begin
      ex_in = '{wb_sel: id_ex.wb_sel, reg_wr_en: id_ex.reg_wr_en, mem_wr_en: id_ex.mem_wr_en,
                mem_ctrl: id_ex.mem_ctrl, pc_next: id_ex.pc_next, alu_result: alu_result,
                store_data: rs2_fwd, rd: id_ex.rd};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             ex_mem <= '0;
      else if (bus.ex_clear)  ex_mem <= '0;
      else if (bus.ex_wr_en)  ex_mem <= ex_in;
   end

   assign bus.ex_jump        = id_ex.jump;
   assign bus.ex_branch      = id_ex.branch;
   assign bus.ex_mem_read    = id_ex.mem_read;
   assign bus.ex_rd          = id_ex.rd;
   assign bus.ex_rs1         = id_ex.rs1;
   assign bus.ex_rs2         = id_ex.rs2;
   assign bus.ex_opcode      = id_ex.opcode;
   assign bus.ex_funct3      = id_ex.funct3;
   assign bus.ex_rs1_fwd     = rs1_fwd;
   assign bus.ex_rs2_fwd     = rs2_fwd;
   assign bus.ex_alu_result  = alu_result;
   assign bus.mem_wb_sel     = ex_mem.wb_sel;
   assign bus.mem_reg_wr_en  = ex_mem.reg_wr_en;
   assign bus.mem_mem_wr_en  = ex_mem.mem_wr_en;
   assign bus.mem_mem_ctrl   = ex_mem.mem_ctrl;
   assign bus.mem_rd         = ex_mem.rd;
   assign bus.mem_pc_next    = ex_mem.pc_next;
   assign bus.mem_alu_result = ex_mem.alu_result;
   assign bus.mem_store_data = ex_mem.store_data;
endmodule

// File: tb/tb_rv_execute_stage.sv
// Bench for rv_execute_stage: ALU vector table, hand-written pipeline sequences, random model check.
module tb_rv_execute_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv_execute_stage_if bus ();
   rv_execute_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic        jump, branch, mem_read, reg_wr_en, mem_wr_en, op1_sel, op2_sel;
      logic [3:0]  alu_op;
      logic [1:0]  wb_sel;
      logic [2:0]  mem_ctrl;
      logic [31:0] pc, pc_next, rs1_data, rs2_data, imm;
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
   } instr_t;

   typedef struct packed {
      logic [1:0]  wb_sel;
      logic        reg_wr_en, mem_wr_en;
      logic [2:0]  mem_ctrl;
      logic [31:0] pc_next, alu, store;
      logic [4:0]  rd;
   } mem_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        op2_sel;
      logic [31:0] exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   instr_t x, m, rx;
   mem_t mm;
   vec_t vecs[17];
   logic [31:0] fwd_exp[4];
   logic [31:0] e_r1, e_r2, e_op1, e_op2, e_alu, r_wb;
   logic [1:0]  r_f1, r_f2;
   logic        r_cid, r_wid, r_cex, r_wex;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input instr_t i);
      bus.id_jump = i.jump;       bus.id_branch = i.branch;     bus.id_mem_read = i.mem_read;
      bus.id_reg_wr_en = i.reg_wr_en; bus.id_mem_wr_en = i.mem_wr_en;
      bus.id_op1_sel = i.op1_sel; bus.id_op2_sel = i.op2_sel;   bus.id_alu_op = i.alu_op;
      bus.id_wb_sel = i.wb_sel;   bus.id_mem_ctrl = i.mem_ctrl; bus.id_pc = i.pc;
      bus.id_pc_next = i.pc_next; bus.id_rs1_data = i.rs1_data; bus.id_rs2_data = i.rs2_data;
      bus.id_imm = i.imm;         bus.id_rd = i.rd;             bus.id_rs1 = i.rs1;
      bus.id_rs2 = i.rs2;         bus.id_opcode = i.opcode;     bus.id_funct3 = i.funct3;
   endtask

   // Reference ALU from the instruction-set definitions, SRA via a sign-extended 64-bit shift.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic [63:0] ext;
      sh = b % 32;
      ext = {{32{a[31]}}, a} >> sh;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << sh;
         4'd3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a >> sh;
         4'd7:  return ext[31:0];
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r, input logic [31:0] mv, input logic [31:0] w);
      if (s == 2'd1) return mv;
      if (s == 2'd2) return w;
      return r;
   endfunction

   initial begin
      vecs[0]  = '{4'd0,  32'd5,         32'd7,         1'b0, 32'd12};
      vecs[1]  = '{4'd1,  32'd3,         32'd5,         1'b1, 32'hFFFFFFFE};
      vecs[2]  = '{4'd3,  32'hFFFFFFFF,  32'd1,         1'b0, 32'd1};
      vecs[3]  = '{4'd4,  32'hFFFFFFFF,  32'd1,         1'b0, 32'd0};
      vecs[4]  = '{4'd7,  32'h80000000,  32'd4,         1'b0, 32'hF8000000};
      vecs[5]  = '{4'd2,  32'd1,         32'd33,        1'b0, 32'd2};
      vecs[6]  = '{4'd12, 32'h1234,      32'd5,         1'b0, 32'd0};
      vecs[7]  = '{4'd10, 32'd5,         32'h12345000,  1'b0, 32'h12345000};
      vecs[8]  = '{4'd5,  32'hF0F0F0F0,  32'hFF00FF00,  1'b1, 32'h0FF00FF0};
      vecs[9]  = '{4'd8,  32'hF0F0F0F0,  32'h0F000000,  1'b0, 32'hFFF0F0F0};
      vecs[10] = '{4'd9,  32'hF0F0F0F0,  32'hFF00FF00,  1'b1, 32'hF000F000};
      vecs[11] = '{4'd6,  32'h80000000,  32'd31,        1'b0, 32'd1};
      vecs[12] = '{4'd7,  32'h12345678,  32'd0,         1'b0, 32'h12345678};
      vecs[13] = '{4'd3,  32'd1,         32'hFFFFFFFF,  1'b1, 32'd0};
      vecs[14] = '{4'd7,  32'h7FFFFFF0,  32'd4,         1'b0, 32'h07FFFFFF};
      vecs[15] = '{4'd15, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'd0};
      vecs[16] = '{4'd2,  32'h80000001,  32'h00000020,  1'b0, 32'h80000001};

      x = '0;
      drive(x);
      bus.id_clear = 1'b0; bus.id_wr_en = 1'b1; bus.ex_clear = 1'b0; bus.ex_wr_en = 1'b1;
      bus.fwd1_sel = 2'd0; bus.fwd2_sel = 2'd0; bus.wb_data = 32'h0;
      #1;
      chk("reset_ex_alu", bus.ex_alu_result, 32'd0);
      chk("reset_mem_alu", bus.mem_alu_result, 32'd0);
      #12 rst_n = 1'b1;
      tick();

      // ALU vector table
      foreach (vecs[i]) begin
         x = '0;
         x.alu_op = vecs[i].op;
         x.op2_sel = vecs[i].op2_sel;
         x.rs1_data = vecs[i].a;
         x.rs2_data = vecs[i].op2_sel ? vecs[i].b : 32'hDEAD_BEEF;
         x.imm = vecs[i].op2_sel ? 32'hCAFE_F00D : vecs[i].b;
         x.rd = 5'(i + 1);
         drive(x);
         tick();
         chk($sformatf("vec%0d_ex_alu", i), bus.ex_alu_result, vecs[i].exp);
         tick();
         chk($sformatf("vec%0d_mem_alu", i), bus.mem_alu_result, vecs[i].exp);
         chk($sformatf("vec%0d_mem_rd", i), bus.mem_rd, 32'(i + 1));
      end

      // Forwarding
      x = '0; x.alu_op = 4'd10; x.imm = 32'h20; x.rd = 5'd3;
      drive(x); tick();
      x = '0; x.rs1_data = 32'd1; x.rs2_data = 32'h55; x.op2_sel = 1'b1;
      drive(x); tick();
      bus.wb_data = 32'h30;
      fwd_exp[0] = 32'd1; fwd_exp[1] = 32'h20; fwd_exp[2] = 32'h30; fwd_exp[3] = 32'd1;
      for (int s = 0; s < 4; s++) begin
         bus.fwd1_sel = 2'(s);
         #1;
         chk($sformatf("fwd1_sel%0d", s), bus.ex_rs1_fwd, fwd_exp[s]);
      end
      bus.fwd1_sel = 2'd0; bus.fwd2_sel = 2'd1;
      #1;
      chk("fwd2_rs2", bus.ex_rs2_fwd, 32'h20);
      chk("fwd2_alu", bus.ex_alu_result, 32'h21);
      x = '0; drive(x); tick();
      bus.fwd2_sel = 2'd0;
      chk("fwd2_store", bus.mem_store_data, 32'h20);
      chk("fwd2_mem_alu", bus.mem_alu_result, 32'h21);

      // EX/MEM hold while ID/EX advances
      bus.ex_wr_en = 1'b0;
      x = '0; x.alu_op = 4'd10; x.imm = 32'h77; x.rd = 5'd9;
      drive(x); tick();
      chk("exhold_ex_rd", bus.ex_rd, 32'd9);
      chk("exhold_mem_alu", bus.mem_alu_result, 32'h21);
      tick();
      chk("exhold_mem_alu2", bus.mem_alu_result, 32'h21);
      chk("exhold_store", bus.mem_store_data, 32'h20);
      bus.ex_wr_en = 1'b1;
      tick();
      chk("exrel_mem_alu", bus.mem_alu_result, 32'h77);
      chk("exrel_mem_rd", bus.mem_rd, 32'd9);

      // JAL-style
      x = '0; x.op1_sel = 1'b1; x.pc = 32'h100; x.imm = 32'd8; x.wb_sel = 2'd2;
      x.pc_next = 32'h104; x.reg_wr_en = 1'b1; x.jump = 1'b1; x.rd = 5'd1;
      drive(x); tick();
      chk("jal_ex_alu", bus.ex_alu_result, 32'h108);
      chk("jal_ex_jump", bus.ex_jump, 32'd1);
      x = '0; drive(x); tick();
      chk("jal_mem_pc_next", bus.mem_pc_next, 32'h104);
      chk("jal_mem_wb_sel", bus.mem_wb_sel, 32'd2);
      chk("jal_mem_reg_wr", bus.mem_reg_wr_en, 32'd1);
      chk("jal_mem_alu", bus.mem_alu_result, 32'h108);

      // ID/EX hold
      x = '0; x.rd = 5'd7; x.opcode = 7'h13;
      drive(x); tick();
      x.rd = 5'd9; bus.id_wr_en = 1'b0;
      drive(x); tick();
      chk("idhold_rd", bus.ex_rd, 32'd7);
      tick();
      chk("idhold_rd2", bus.ex_rd, 32'd7);
      bus.id_wr_en = 1'b1;
      tick();
      chk("idrel_rd", bus.ex_rd, 32'd9);

      // Clear beats hold; EX/MEM clear
      x = '0; x.reg_wr_en = 1'b1; x.jump = 1'b1; x.branch = 1'b1; x.mem_read = 1'b1;
      x.rd = 5'd5; x.imm = 32'd4; x.opcode = 7'h6F;
      drive(x); bus.id_clear = 1'b1; bus.id_wr_en = 1'b0;
      tick();
      chk("idclr_rd", bus.ex_rd, 32'd0);
      chk("idclr_jump", bus.ex_jump, 32'd0);
      chk("idclr_branch", bus.ex_branch, 32'd0);
      chk("idclr_mem_read", bus.ex_mem_read, 32'd0);
      chk("idclr_opcode", bus.ex_opcode, 32'd0);
      chk("idclr_alu", bus.ex_alu_result, 32'd0);
      bus.id_clear = 1'b0; bus.id_wr_en = 1'b1;
      tick();
      chk("idload_rd", bus.ex_rd, 32'd5);
      bus.ex_clear = 1'b1;
      tick();
      chk("exclr_reg_wr", bus.mem_reg_wr_en, 32'd0);
      chk("exclr_rd", bus.mem_rd, 32'd0);
      chk("exclr_alu", bus.mem_alu_result, 32'd0);
      bus.ex_clear = 1'b0;
      tick();
      chk("exload_rd", bus.mem_rd, 32'd5);

      // Async reset with both registers loaded; release mid-cycle
      rst_n = 1'b0;
      #1;
      chk("rst_ex_rd", bus.ex_rd, 32'd0);
      chk("rst_ex_jump", bus.ex_jump, 32'd0);
      chk("rst_ex_alu", bus.ex_alu_result, 32'd0);
      chk("rst_mem_rd", bus.mem_rd, 32'd0);
      chk("rst_mem_alu", bus.mem_alu_result, 32'd0);
      chk("rst_mem_reg_wr", bus.mem_reg_wr_en, 32'd0);
      #2 rst_n = 1'b1;
      #1;
      chk("rstrel_ex_rd", bus.ex_rd, 32'd0);
      chk("rstrel_mem_pc_next", bus.mem_pc_next, 32'd0);

      // Random stimulus against the model
      m = '0; mm = '0;
      for (int it = 0; it < 400; it++) begin
         rx = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         r_cid = ($urandom_range(0, 9) == 0);
         r_wid = ($urandom_range(0, 7) != 0);
         r_cex = ($urandom_range(0, 9) == 0);
         r_wex = ($urandom_range(0, 7) != 0);
         r_f1 = 2'($urandom_range(0, 3));
         r_f2 = 2'($urandom_range(0, 3));
         r_wb = $urandom;
         drive(rx);
         bus.id_clear = r_cid; bus.id_wr_en = r_wid; bus.ex_clear = r_cex; bus.ex_wr_en = r_wex;
         bus.fwd1_sel = r_f1; bus.fwd2_sel = r_f2; bus.wb_data = r_wb;
         #1;
         e_r1 = pick(r_f1, m.rs1_data, mm.alu, r_wb);
         e_r2 = pick(r_f2, m.rs2_data, mm.alu, r_wb);
         e_op1 = m.op1_sel ? m.pc : e_r1;
         e_op2 = m.op2_sel ? e_r2 : m.imm;
         e_alu = ref_alu(m.alu_op, e_op1, e_op2);
         chk("rnd_rs1_fwd", bus.ex_rs1_fwd, e_r1);
         chk("rnd_rs2_fwd", bus.ex_rs2_fwd, e_r2);
         chk("rnd_alu", bus.ex_alu_result, e_alu);
         @(posedge clk);
         if (r_cex) mm = '0;
         else if (r_wex) mm = '{m.wb_sel, m.reg_wr_en, m.mem_wr_en, m.mem_ctrl, m.pc_next, e_alu, e_r2, m.rd};
         if (r_cid) m = '0;
         else if (r_wid) m = rx;
         #1;
         chk("rnd_ex_ctl", {bus.ex_jump, bus.ex_branch, bus.ex_mem_read, bus.ex_rd, bus.ex_rs1,
                            bus.ex_rs2, bus.ex_opcode, bus.ex_funct3},
             {m.jump, m.branch, m.mem_read, m.rd, m.rs1, m.rs2, m.opcode, m.funct3});
         chk("rnd_mem_ctl", {bus.mem_wb_sel, bus.mem_reg_wr_en, bus.mem_mem_wr_en, bus.mem_mem_ctrl, bus.mem_rd},
             {mm.wb_sel, mm.reg_wr_en, mm.mem_wr_en, mm.mem_ctrl, mm.rd});
         chk("rnd_mem_pc_next", bus.mem_pc_next, mm.pc_next);
         chk("rnd_mem_alu", bus.mem_alu_result, mm.alu);
         chk("rnd_mem_store", bus.mem_store_data, mm.store);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
